tank_move_sched: RTL



---
 rtl/tank_pkg.sv | 28 ++
 rtl/tank_step_calc.sv | 38 +++
 rtl/tank_move_sched.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// Shared types and helpers for the tank movement scheduler.
package tank_pkg;
    localparam int NUM_TANKS = 5;
    localparam int GRID_W    = 64;
    localparam int GRID_H    = 48;
    localparam int COORD_W   = 6;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SEL, ST_CALC, ST_CHECK, ST_COMMIT, ST_DONE
    } state_e;

    // Extract the 6-bit coordinate field of tank i from a packed vector.
    function automatic logic [COORD_W-1:0] coord_of(input logic [NUM_TANKS*COORD_W-1:0] v,
                                                    input int i);
        logic [NUM_TANKS*COORD_W-1:0] s;
        s = v >> (COORD_W * i);
        return s[COORD_W-1:0];
    endfunction

    // Extract the 2-bit direction field of tank i from a packed vector.
    function automatic logic [1:0] dir_of(input logic [NUM_TANKS*2-1:0] v, input int i);
        logic [NUM_TANKS*2-1:0] s;
        s = v >> (2 * i);
        return s[1:0];
    endfunction
endpackage

// File: rtl/tank_step_calc.sv
// Single-step candidate cell and grid bounds check; no wrap-around.
module tank_step_calc
    import tank_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [1:0]         dir,
    output logic [COORD_W-1:0] cand_x,
    output logic [COORD_W-1:0] cand_y,
    output logic               out_of_bounds
);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

    always_comb begin
        cand_x        = x;
        cand_y        = y;
        out_of_bounds = 1'b0;
        case (dir)
            DIR_UP: begin
                out_of_bounds = (y == '0);
                cand_y        = y - COORD_W'(1);
            end
            DIR_DOWN: begin
                out_of_bounds = (y == Y_MAX);
                cand_y        = y + COORD_W'(1);
            end
            DIR_LEFT: begin
                out_of_bounds = (x == '0);
                cand_x        = x - COORD_W'(1);
            end
            default: begin
                out_of_bounds = (x == X_MAX);
                cand_x        = x + COORD_W'(1);
            end
        endcase
    end
endmodule

// File: rtl/tank_move_sched.sv
// Per-frame tank movement scheduler: serialises moves in tank-index order.
// Define TANK_COLLIDE_EN to add the tank-vs-tank occupancy check.
module tank_move_sched
    import tank_pkg::*;
#(
    parameter logic [29:0] INIT_X = 30'h0,
    parameter logic [29:0] INIT_Y = 30'h0
) (
    input  logic        clk_25m,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [4:0]  tank_alive,
    input  logic [4:0]  mv_req,
    input  logic [9:0]  mv_dir,
    output logic [29:0] tank_x,
    output logic [29:0] tank_y,
    output logic [9:0]  tank_dir,
    output logic [4:0]  mv_ack,
    output logic [4:0]  mv_blocked,
    output logic        busy,
    output logic        done,
    output logic        frame_overrun
);
    logic [COORD_W-1:0] x_reg [NUM_TANKS];
    logic [COORD_W-1:0] y_reg [NUM_TANKS];
    logic [1:0]         face_reg [NUM_TANKS];
    logic [1:0]         dir_reg [NUM_TANKS];
    logic [COORD_W-1:0] init_x_arr [NUM_TANKS];
    logic [COORD_W-1:0] init_y_arr [NUM_TANKS];
    logic [1:0]         mv_dir_arr [NUM_TANKS];

    state_e             state_reg;
    logic [2:0]         idx_reg;
    logic [4:0]         alive_reg, req_reg;
    logic [COORD_W-1:0] cand_x_reg, cand_y_reg;
    logic               bad_reg;
    logic [4:0]         mv_ack_reg, mv_blocked_reg;
    logic               busy_reg, done_reg, overrun_reg;

    logic [COORD_W-1:0] step_x, step_y;
    logic               step_oob;
    logic               last_tank;
`ifdef TANK_COLLIDE_EN
    logic [2:0]         chk_reg;
    logic [4:0]         hit_vec;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TANKS; gi++) begin : g_tank
            assign init_x_arr[gi] = coord_of(INIT_X, gi);
            assign init_y_arr[gi] = coord_of(INIT_Y, gi);
            assign mv_dir_arr[gi] = dir_of(mv_dir, gi);
            assign tank_x[gi*COORD_W +: COORD_W] = x_reg[gi];
            assign tank_y[gi*COORD_W +: COORD_W] = y_reg[gi];
            assign tank_dir[gi*2 +: 2]           = face_reg[gi];
`ifdef TANK_COLLIDE_EN
            // Committed positions: tanks already moved this pass block at their new cell.
            assign hit_vec[gi] = alive_reg[gi] && (cand_x_reg == x_reg[gi])
                                 && (cand_y_reg == y_reg[gi]);
`endif
        end
    endgenerate

    tank_step_calc u_step (
        .x             (x_reg[idx_reg]),
        .y             (y_reg[idx_reg]),
        .dir           (dir_reg[idx_reg]),
        .cand_x        (step_x),
        .cand_y        (step_y),
        .out_of_bounds (step_oob)
    );

    assign last_tank = (idx_reg == 3'(NUM_TANKS - 1));

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            x_reg          <= init_x_arr;
            y_reg          <= init_y_arr;
            face_reg       <= '{default: 2'd0};
            dir_reg        <= '{default: 2'd0};
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            alive_reg      <= '0;
            req_reg        <= '0;
            cand_x_reg     <= '0;
            cand_y_reg     <= '0;
            bad_reg        <= 1'b0;
            mv_ack_reg     <= '0;
            mv_blocked_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef TANK_COLLIDE_EN
            chk_reg        <= '0;
`endif
        end else begin
            mv_ack_reg     <= '0;
            mv_blocked_reg <= '0;
            done_reg       <= 1'b0;
            if (frame_tick && state_reg != ST_IDLE) overrun_reg <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (frame_tick) begin
                        alive_reg <= tank_alive;
                        req_reg   <= mv_req;
                        dir_reg   <= mv_dir_arr;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    if (alive_reg[idx_reg] && req_reg[idx_reg]) begin
                        state_reg <= ST_CALC;
                    end else if (last_tank) begin
                        state_reg <= ST_DONE;
                    end else begin
                        idx_reg   <= idx_reg + 3'd1;
                        state_reg <= ST_SEL;
                    end
                end
                ST_CALC: begin
                    cand_x_reg <= step_x;
                    cand_y_reg <= step_y;
                    bad_reg    <= step_oob;
`ifdef TANK_COLLIDE_EN
                    chk_reg    <= '0;
                    state_reg  <= ST_CHECK;
`else
                    state_reg  <= ST_COMMIT;
`endif
                end
`ifdef TANK_COLLIDE_EN
                ST_CHECK: begin
                    if (chk_reg != idx_reg && hit_vec[chk_reg]) bad_reg <= 1'b1;
                    if (chk_reg == 3'(NUM_TANKS - 1)) state_reg <= ST_COMMIT;
                    else chk_reg <= chk_reg + 3'd1;
                end
`endif
                ST_COMMIT: begin
                    // Facing always follows the request, even when the move is refused.
                    face_reg[idx_reg] <= dir_reg[idx_reg];
                    if (!bad_reg) begin
                        x_reg[idx_reg]      <= cand_x_reg;
                        y_reg[idx_reg]      <= cand_y_reg;
                        mv_ack_reg[idx_reg] <= 1'b1;
                    end else begin
                        mv_blocked_reg[idx_reg] <= 1'b1;
                    end
                    if (last_tank) begin
                        state_reg <= ST_DONE;
                    end else begin
                        idx_reg   <= idx_reg + 3'd1;
                        state_reg <= ST_SEL;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mv_ack        = mv_ack_reg;
    assign mv_blocked    = mv_blocked_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign frame_overrun = overrun_reg;
endmodule
